keccak_ctrl_fsm: RTL and testbench
==================================

# keccak_ctrl_fsm

Parametrised control unit for the Keccak-f[1600] datapath. It sequences absorb, permutation rounds and multi-block squeeze for all six FIPS-202 modes (SHA3-224/256/384/512, SHAKE128/256). It sits between the input block buffer and the output buffer, drives the round core's round index, and supersedes the two-mode controller with per-mode rate selection and iterated SHAKE squeezing.

## Interface
- ROUNDS, 24: permutation rounds per block.
- RDCTR_W, 5: round counter width; must satisfy 2^RDCTR_W >= ROUNDS.
- LEN_W, 32: width of requested output length in bits.
- CLR_ROUND, 4: round index at which block_ready_clr/msg_end_clr pulse.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- block_ready  in  1  input buffer holds a full padded block.
- msg_end  in  1  held block is the last of the message.
- mode  in  3  0..3 SHA3-224/256/384/512, 4 SHAKE128, 5 SHAKE256, 6/7 reserved.
- out_len  in  LEN_W  SHAKE output length in bits; sampled with the first block.
- output_busy  in  1  output buffer still draining.
- block_ready_clr, msg_end_clr  out  1  one-cycle clears to input buffer.
- absorb  out  1  XOR input block into state this cycle.
- zero_state  out  1  state is treated as zero for this absorb (first block).
- round_en  out  1  round core advances state this cycle.
- round_idx  out  RDCTR_W  current round constant index.
- output_write  out  1  one-cycle pulse: copy rate portion to output buffer.
- output_size  out  11  bits valid in this output block.
- rate_bits  out  11  rate of the latched mode.
- mode_ctrl  out  3  latched mode.
- busy  out  1  message in progress.
- err_mode  out  1  one-cycle pulse: reserved mode rejected.

## Operation
- Rates: 1152, 1088, 832, 576, 1344, 1088 for modes 0..5. Digest bits: 224, 256, 384, 512 for modes 0..3. SHAKE uses out_len.
- States: IDLE, PERM, FINAL, OUT, SQZ, OWAIT.
- IDLE, block_ready=1, valid mode: absorb=1. If first block, zero_state=1 and latch mode, length and busy=1. Go to FINAL if msg_end=1, else PERM.
- IDLE, block_ready=1, mode 6/7: err_mode=1, block_ready_clr=1, msg_end_clr=1, no absorb, stay IDLE, busy unchanged.
- Mode and out_len are ignored on blocks after the first until the message completes.
- PERM/FINAL/SQZ: round_en=1, round_idx counts 0..ROUNDS-1, one per cycle.
  - PERM and FINAL pulse block_ready_clr at round_idx==CLR_ROUND; FINAL also pulses msg_end_clr there.
  - After the last round: PERM goes to IDLE, FINAL and SQZ go to OUT.
- OUT, output_busy=0: output_write=1, output_size=min(remaining, rate), and remaining is reduced by output_size.
  - If remaining becomes 0: go to IDLE and clear busy.
  - Otherwise go to SQZ (a fresh permutation with no absorb).
- OUT, output_busy=1: go to OWAIT, which returns to OUT on the first cycle output_busy=0.
- SHAKE with out_len=0: OUT produces no output_write, clears busy, and goes to IDLE.
- Remaining is a LEN_W-bit register. output_size is the low 11 bits of the min.

## Timing
- Reset: state IDLE, round counter 0, remaining 0, mode_ctrl 0, rate_bits 1152, busy 0. All pulse outputs are 0.
- Block latency: absorb in cycle T, rounds in T+1..T+ROUNDS. The next block can be absorbed no earlier than T+ROUNDS+1.
- First output_write comes at T+ROUNDS+1 after the final block's absorb when output_busy=0.
- Each extra squeeze block costs ROUNDS+1 cycles.
- block_ready and msg_end are only sampled in IDLE. output_busy is only sampled in OUT/OWAIT.
- A reset asserted in any state takes effect on the next edge and aborts the message. No clear pulses are issued.

## Structure
- Shared package keccak_pkg: mode encodings, rate and digest constant arrays, state enum, and ROUNDS default.
- One sub-module: keccak_round_ctr (load/enable up-counter of width RDCTR_W with terminal-count flag at ROUNDS-1).

## Test plan
- SHA3-256, one block with msg_end=1: absorb+zero_state at T, 24 round_en cycles, msg_end_clr at T+5, output_write at T+25 with output_size=256, busy low at T+26.
- SHA3-512, three blocks: only the first has zero_state=1, three permutations, one output_write of size 512.
- SHAKE128, out_len=3000: output_write sizes 1344, 1344, 312, with 25 cycles between writes.
- SHAKE256, out_len=0: no output_write, busy drops the cycle after FINAL ends.
- output_busy held high for 10 cycles at OUT: FSM holds in OWAIT, then a single output_write. A new block_ready asserted during OWAIT is not absorbed.
- mode=7 with block_ready: err_mode, both clears, no round_en. Also apply rst at round 12 of a SHAKE message: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak-f[1600] controller: mode encodings,
// per-mode rate and digest tables, controller states and the default round count.
package keccak_pkg;

    localparam int KECCAK_ROUNDS = 24;

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } mode_e;

    localparam logic [10:0] RATE_BITS [0:5] = '{
        11'd1152, 11'd1088, 11'd832, 11'd576, 11'd1344, 11'd1088
    };

    localparam logic [9:0] DIGEST_BITS [0:3] = '{
        10'd224, 10'd256, 10'd384, 10'd512
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PERM,
        ST_FINAL,
        ST_OUT,
        ST_SQZ,
        ST_OWAIT
    } state_e;

    function automatic logic mode_valid(input logic [2:0] m);
        return m <= MODE_SHAKE256;
    endfunction

    function automatic logic is_shake(input logic [2:0] m);
        return (m == MODE_SHAKE128) || (m == MODE_SHAKE256);
    endfunction

    function automatic logic [10:0] rate_of(input logic [2:0] m);
        if (mode_valid(m)) begin
            return RATE_BITS[m];
        end
        return RATE_BITS[0];
    endfunction

    // Only meaningful for the fixed-length modes 0..3.
    function automatic logic [9:0] digest_of(input logic [2:0] m);
        return DIGEST_BITS[m[1:0]];
    endfunction

endpackage

// File: rtl/keccak_round_ctr.sv
// Round counter for the permutation: synchronous load-to-zero and enable,
// with a terminal-count flag on the last round index.
module keccak_round_ctr
#(
    parameter int ROUNDS  = 24,
    parameter int RDCTR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    output logic [RDCTR_W-1:0] count,
    output logic               tc
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == RDCTR_W'(ROUNDS - 1));

endmodule

// File: rtl/keccak_ctrl_fsm.sv
// Keccak-f[1600] control unit: absorb, permutation rounds and multi-block
// squeeze for SHA3-224/256/384/512 and SHAKE128/256, with registered outputs.
module keccak_ctrl_fsm
    import keccak_pkg::*;
#(
    parameter int ROUNDS    = KECCAK_ROUNDS,
    parameter int RDCTR_W   = 5,
    parameter int LEN_W     = 32,
    parameter int CLR_ROUND = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               block_ready,
    input  logic               msg_end,
    input  logic [2:0]         mode,
    input  logic [LEN_W-1:0]   out_len,
    input  logic               output_busy,
    output logic               block_ready_clr,
    output logic               msg_end_clr,
    output logic               absorb,
    output logic               zero_state,
    output logic               round_en,
    output logic [RDCTR_W-1:0] round_idx,
    output logic               output_write,
    output logic [10:0]        output_size,
    output logic [10:0]        rate_bits,
    output logic [2:0]         mode_ctrl,
    output logic               busy,
    output logic               err_mode
);

    state_e             state;
    logic [LEN_W-1:0]   remaining;
    logic               finish;
    logic [RDCTR_W-1:0] cnt;
    logic               cnt_tc;
    logic               cnt_load;
    logic               cnt_en;
    logic               blk_avail;
    logic               first_blk;
    logic               start_blk;
    logic               reject_blk;
    logic               out_zero;
    logic               out_last;
    logic [LEN_W-1:0]   rate_ext;
    logic [LEN_W-1:0]   out_amt;

    // The state register leads the outputs by one cycle: the state seen at an
    // edge names what the following cycle does. A block is not re-sampled
    // while its clear pulse is still in flight to the input buffer.
    always_comb begin
        blk_avail  = block_ready && !block_ready_clr;
        first_blk  = !busy || finish;
        start_blk  = (state == ST_IDLE) && blk_avail && (!first_blk || mode_valid(mode));
        reject_blk = (state == ST_IDLE) && blk_avail && first_blk && !mode_valid(mode);
        rate_ext   = LEN_W'(rate_bits);
        out_last   = (remaining <= rate_ext);
        out_amt    = out_last ? remaining : rate_ext;
        out_zero   = (remaining == '0);
        cnt_en     = state inside {ST_PERM, ST_FINAL, ST_SQZ};
        cnt_load   = start_blk ||
                     ((state == ST_OUT) && !out_zero && !output_busy && !out_last);
    end

    keccak_round_ctr #(
        .ROUNDS  (ROUNDS),
        .RDCTR_W (RDCTR_W)
    ) u_round_ctr (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // finish marks the cycle the message's last output step is visible;
    // busy falls one cycle later unless a new message starts on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            remaining       <= '0;
            finish          <= 1'b0;
            busy            <= 1'b0;
            mode_ctrl       <= 3'd0;
            rate_bits       <= RATE_BITS[0];
            absorb          <= 1'b0;
            zero_state      <= 1'b0;
            round_en        <= 1'b0;
            round_idx       <= '0;
            block_ready_clr <= 1'b0;
            msg_end_clr     <= 1'b0;
            output_write    <= 1'b0;
            output_size     <= '0;
            err_mode        <= 1'b0;
        end else begin
            absorb          <= 1'b0;
            zero_state      <= 1'b0;
            round_en        <= 1'b0;
            block_ready_clr <= 1'b0;
            msg_end_clr     <= 1'b0;
            output_write    <= 1'b0;
            err_mode        <= 1'b0;
            finish          <= 1'b0;
            if (finish) begin
                busy <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_blk) begin
                        absorb     <= 1'b1;
                        zero_state <= first_blk;
                        if (first_blk) begin
                            busy      <= 1'b1;
                            mode_ctrl <= mode;
                            rate_bits <= rate_of(mode);
                            remaining <= is_shake(mode) ? out_len
                                                        : LEN_W'(digest_of(mode));
                        end
                        state <= msg_end ? ST_FINAL : ST_PERM;
                    end else if (reject_blk) begin
                        err_mode        <= 1'b1;
                        block_ready_clr <= 1'b1;
                        msg_end_clr     <= 1'b1;
                    end
                end

                ST_PERM, ST_FINAL, ST_SQZ: begin
                    round_en  <= 1'b1;
                    round_idx <= cnt;
                    if ((cnt == RDCTR_W'(CLR_ROUND)) && (state != ST_SQZ)) begin
                        block_ready_clr <= 1'b1;
                        msg_end_clr     <= (state == ST_FINAL);
                    end
                    if (cnt_tc) begin
                        state <= (state == ST_PERM) ? ST_IDLE : ST_OUT;
                    end
                end

                ST_OUT: begin
                    if (out_zero) begin
                        finish <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (output_busy) begin
                        state <= ST_OWAIT;
                    end else begin
                        output_write <= 1'b1;
                        output_size  <= out_amt[10:0];
                        remaining    <= remaining - out_amt;
                        if (out_last) begin
                            finish <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_SQZ;
                        end
                    end
                end

                ST_OWAIT: begin
                    if (!output_busy) begin
                        state <= ST_OUT;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_ctrl_fsm.sv
// Scenario bench for keccak_ctrl_fsm: an input-buffer model plus a queue of
// expected output block sizes compared as the DUT emits output_write pulses.
module tb_keccak_ctrl_fsm;

    localparam int ROUNDS    = 24;
    localparam int RDCTR_W   = 5;
    localparam int LEN_W     = 32;
    localparam int CLR_ROUND = 4;

    logic               clk;
    logic               rst;
    logic               block_ready;
    logic               msg_end;
    logic [2:0]         mode;
    logic [LEN_W-1:0]   out_len;
    logic               output_busy;
    logic               block_ready_clr;
    logic               msg_end_clr;
    logic               absorb;
    logic               zero_state;
    logic               round_en;
    logic [RDCTR_W-1:0] round_idx;
    logic               output_write;
    logic [10:0]        output_size;
    logic [10:0]        rate_bits;
    logic [2:0]         mode_ctrl;
    logic               busy;
    logic               err_mode;

    typedef struct {
        int cyc;
        int size;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    wr_t got_q[$];
    int  exp_q[$];
    int  ridx_q[$];
    int  n_absorb, n_zero, n_round, n_err, last_absorb, last_mclr;

    keccak_ctrl_fsm #(
        .ROUNDS    (ROUNDS),
        .RDCTR_W   (RDCTR_W),
        .LEN_W     (LEN_W),
        .CLR_ROUND (CLR_ROUND)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .block_ready     (block_ready),
        .msg_end         (msg_end),
        .mode            (mode),
        .out_len         (out_len),
        .output_busy     (output_busy),
        .block_ready_clr (block_ready_clr),
        .msg_end_clr     (msg_end_clr),
        .absorb          (absorb),
        .zero_state      (zero_state),
        .round_en        (round_en),
        .round_idx       (round_idx),
        .output_write    (output_write),
        .output_size     (output_size),
        .rate_bits       (rate_bits),
        .mode_ctrl       (mode_ctrl),
        .busy            (busy),
        .err_mode        (err_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: sample at the falling edge, log events, and let the input
    // buffer model drop its flags when the DUT clears them.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (absorb) begin
            n_absorb++;
            last_absorb = cyc;
            if (zero_state) n_zero++;
        end
        if (round_en) begin
            n_round++;
            ridx_q.push_back(int'(round_idx));
        end
        if (output_write) got_q.push_back('{cyc, int'(output_size)});
        if (msg_end_clr) last_mclr = cyc;
        if (err_mode) n_err++;
        if (block_ready_clr) block_ready = 1'b0;
        if (msg_end_clr) msg_end = 1'b0;
    endtask

    task automatic clear_mon();
        n_absorb = 0; n_zero = 0; n_round = 0; n_err = 0;
        last_absorb = -1; last_mclr = -1;
        got_q.delete(); ridx_q.delete(); exp_q.delete();
    endtask

    task automatic wait_absorb(input int n, input int budget, output bit ok);
        int k = 0;
        while (n_absorb < n && k < budget) begin tick(); k++; end
        ok = (n_absorb >= n);
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        int k = 0;
        while (got_q.size() < n && k < budget) begin tick(); k++; end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        block_ready = 1'b0; msg_end = 1'b0; mode = 3'd0; out_len = '0; output_busy = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++;
        if (rate_bits !== 11'd1152) begin errors++; $display("FAIL reset_rate got %0d want 1152", rate_bits); end
        checks++;
        if (mode_ctrl !== 3'd0 || round_idx !== '0) begin
            errors++; $display("FAIL reset_mode_idx got %0d/%0d want 0/0", mode_ctrl, round_idx);
        end
        checks++;
        if ({absorb, zero_state, round_en, block_ready_clr, msg_end_clr, output_write, err_mode} !== 7'b0) begin
            errors++; $display("FAIL reset_pulses got %b want 0000000",
                {absorb, zero_state, round_en, block_ready_clr, msg_end_clr, output_write, err_mode});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sha3_256_single();
        bit ok; int t0; wr_t w; int e;
        clear_mon();
        exp_q.push_back(256);
        block_ready = 1'b1; msg_end = 1'b1; mode = 3'd1; out_len = '0;
        wait_absorb(1, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL s256_absorb got none want 1"); return; end
        t0 = last_absorb;
        checks++;
        if (n_zero != 1) begin errors++; $display("FAIL s256_zero_state got %0d want 1", n_zero); end
        wait_writes(1, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL s256_write_timeout got 0 want 1"); return; end
        checks++;
        if (got_q[0].cyc != t0 + ROUNDS + 1) begin
            errors++; $display("FAIL s256_write_time got T+%0d want T+%0d", got_q[0].cyc - t0, ROUNDS + 1);
        end
        checks++;
        if (last_mclr != t0 + CLR_ROUND + 1) begin
            errors++; $display("FAIL s256_msg_end_clr got T+%0d want T+%0d", last_mclr - t0, CLR_ROUND + 1);
        end
        checks++;
        if (ridx_q.size() != ROUNDS) begin
            errors++; $display("FAIL s256_round_count got %0d want %0d", ridx_q.size(), ROUNDS);
        end else begin
            checks++;
            if (ridx_q[0] != 0 || ridx_q[ROUNDS-1] != ROUNDS - 1) begin
                errors++; $display("FAIL s256_round_idx got %0d..%0d want 0..%0d", ridx_q[0], ridx_q[ROUNDS-1], ROUNDS - 1);
            end
        end
        w = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (w.size != e) begin errors++; $display("FAIL s256_size got %0d want %0d", w.size, e); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL s256_busy_at_write got %0b want 1", busy); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL s256_busy_after got %0b want 0", busy); end
        checks++;
        if (rate_bits !== 11'd1088 || mode_ctrl !== 3'd1) begin
            errors++; $display("FAIL s256_latched got %0d/%0d want 1088/1", rate_bits, mode_ctrl);
        end
    endtask

    task automatic test_sha3_512_multi();
        bit ok; wr_t w; int e; int k;
        clear_mon();
        exp_q.push_back(512);
        for (int b = 0; b < 3; b++) begin
            block_ready = 1'b1;
            msg_end = (b == 2);
            mode = (b == 0) ? 3'd3 : 3'd4;
            out_len = (b == 0) ? '0 : LEN_W'(5);
            wait_absorb(b + 1, 40, ok);
            if (!ok) break;
            k = 0;
            while (block_ready && k < 40) begin tick(); k++; end
        end
        checks++;
        if (n_absorb != 3 || n_zero != 1) begin
            errors++; $display("FAIL s512_absorbs got %0d/%0d want 3/1", n_absorb, n_zero);
        end
        wait_writes(1, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL s512_write_timeout got 0 want 1"); return; end
        checks++;
        if (n_round != 3 * ROUNDS) begin errors++; $display("FAIL s512_rounds got %0d want %0d", n_round, 3 * ROUNDS); end
        w = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (w.size != e || mode_ctrl !== 3'd3) begin
            errors++; $display("FAIL s512_size_mode got %0d/%0d want %0d/3", w.size, mode_ctrl, e);
        end
        repeat (30) tick();
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL s512_extra_writes got %0d want 0", got_q.size()); end
    endtask

    task automatic test_shake128_multi();
        bit ok; int t0; int rem; int prev; wr_t w; int e;
        clear_mon();
        rem = 3000;
        while (rem > 0) begin
            e = (rem < 1344) ? rem : 1344;
            exp_q.push_back(e);
            rem -= e;
        end
        block_ready = 1'b1; msg_end = 1'b1; mode = 3'd4; out_len = LEN_W'(3000);
        wait_absorb(1, 10, ok);
        t0 = last_absorb;
        wait_writes(3, 120, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL shk128_writes got %0d want 3", got_q.size()); return; end
        checks++;
        if (got_q[0].cyc != t0 + ROUNDS + 1) begin
            errors++; $display("FAIL shk128_first_time got T+%0d want T+%0d", got_q[0].cyc - t0, ROUNDS + 1);
        end
        prev = -1;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            w = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (w.size != e) begin errors++; $display("FAIL shk128_size got %0d want %0d", w.size, e); end
            if (prev >= 0) begin
                checks++;
                if (w.cyc - prev != ROUNDS + 1) begin
                    errors++; $display("FAIL shk128_gap got %0d want %0d", w.cyc - prev, ROUNDS + 1);
                end
            end
            prev = w.cyc;
        end
        wait_idle(10, ok);
        checks++;
        if (!ok || got_q.size() != 0) begin
            errors++; $display("FAIL shk128_end got busy=%0b extra=%0d want 0/0", busy, got_q.size());
        end
    endtask

    task automatic test_shake256_zero();
        bit ok; int t0;
        clear_mon();
        block_ready = 1'b1; msg_end = 1'b1; mode = 3'd5; out_len = '0;
        wait_absorb(1, 10, ok);
        t0 = last_absorb;
        while (cyc < t0 + ROUNDS + 1) tick();
        checks++;
        if (busy !== 1'b1 || n_round != ROUNDS) begin
            errors++; $display("FAIL shk256z_rounds got busy=%0b rounds=%0d want 1/%0d", busy, n_round, ROUNDS);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL shk256z_busy got %0b want 0", busy); end
        repeat (5) tick();
        checks++;
        if (got_q.size() != 0 || rate_bits !== 11'd1088 || mode_ctrl !== 3'd5) begin
            errors++; $display("FAIL shk256z_state got writes=%0d rate=%0d mode=%0d want 0/1088/5",
                got_q.size(), rate_bits, mode_ctrl);
        end
    endtask

    task automatic test_back_to_back_owait();
        bit ok; int t0; int x; wr_t w; int e;
        clear_mon();
        exp_q.push_back(256);
        exp_q.push_back(256);
        output_busy = 1'b1;
        block_ready = 1'b1; msg_end = 1'b1; mode = 3'd1; out_len = '0;
        wait_absorb(1, 10, ok);
        t0 = last_absorb;
        while (cyc < t0 + ROUNDS + 1) tick();
        block_ready = 1'b1; msg_end = 1'b1;
        repeat (10) tick();
        checks++;
        if (got_q.size() != 0 || n_absorb != 1) begin
            errors++; $display("FAIL owait_hold got writes=%0d absorbs=%0d want 0/1", got_q.size(), n_absorb);
        end
        output_busy = 1'b0;
        x = cyc;
        wait_writes(1, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL owait_write_timeout got 0 want 1"); return; end
        checks++;
        if (got_q[0].cyc != x + 2 || n_absorb != 1) begin
            errors++; $display("FAIL owait_release got X+%0d absorbs=%0d want X+2/1", got_q[0].cyc - x, n_absorb);
        end
        w = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (w.size != e) begin errors++; $display("FAIL owait_size got %0d want %0d", w.size, e); end
        tick();
        checks++;
        if (absorb !== 1'b1 || zero_state !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart got absorb=%0b zero=%0b busy=%0b want 1/1/1", absorb, zero_state, busy);
        end
        wait_writes(1, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_write_timeout got 0 want 1"); return; end
        w = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (w.size != e) begin errors++; $display("FAIL b2b_size got %0d want %0d", w.size, e); end
        wait_idle(10, ok);
    endtask

    task automatic test_err_mode();
        int k; logic brc; logic mec;
        clear_mon();
        brc = 1'b0; mec = 1'b0;
        block_ready = 1'b1; msg_end = 1'b1; mode = 3'd7; out_len = '0;
        k = 0;
        while (n_err == 0 && k < 5) begin
            tick();
            k++;
            if (err_mode) begin brc = block_ready_clr; mec = msg_end_clr; end
        end
        checks++;
        if (n_err != 1 || brc !== 1'b1 || mec !== 1'b1) begin
            errors++; $display("FAIL err_pulse got err=%0d clr=%0b%0b want 1/11", n_err, brc, mec);
        end
        repeat (8) tick();
        checks++;
        if (n_err != 1 || n_round != 0 || n_absorb != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL err_quiet got err=%0d rounds=%0d absorbs=%0d busy=%0b want 1/0/0/0",
                n_err, n_round, n_absorb, busy);
        end
        mode = 3'd0;
    endtask

    task automatic test_reset_midmsg();
        bit ok; int k;
        clear_mon();
        block_ready = 1'b1; msg_end = 1'b1; mode = 3'd4; out_len = LEN_W'(3000);
        wait_absorb(1, 10, ok);
        k = 0;
        while (!(round_en && round_idx == RDCTR_W'(12)) && k < 30) begin tick(); k++; end
        checks++;
        if (!(round_en && round_idx == RDCTR_W'(12))) begin
            errors++; $display("FAIL rstmid_round12 got idx=%0d want 12", round_idx);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (round_en !== 1'b0 || round_idx !== '0 || busy !== 1'b0 || mode_ctrl !== 3'd0 || rate_bits !== 11'd1152) begin
            errors++; $display("FAIL rstmid_state got en=%0b idx=%0d busy=%0b mode=%0d rate=%0d want 0/0/0/0/1152",
                round_en, round_idx, busy, mode_ctrl, rate_bits);
        end
        checks++;
        if ({absorb, zero_state, block_ready_clr, msg_end_clr, output_write, err_mode} !== 6'b0) begin
            errors++; $display("FAIL rstmid_pulses got %b want 000000",
                {absorb, zero_state, block_ready_clr, msg_end_clr, output_write, err_mode});
        end
        rst = 1'b0;
        repeat (40) tick();
        checks++;
        if (got_q.size() != 0 || n_absorb != 1) begin
            errors++; $display("FAIL rstmid_aborted got writes=%0d absorbs=%0d want 0/1", got_q.size(), n_absorb);
        end
    endtask

    initial begin
        rst = 1'b1;
        block_ready = 1'b0; msg_end = 1'b0; mode = 3'd0; out_len = '0; output_busy = 1'b0;
        test_reset();
        test_sha3_256_single();
        test_sha3_512_multi();
        test_shake128_multi();
        test_shake256_zero();
        test_back_to_back_owait();
        test_err_mode();
        test_reset_midmsg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
